async_sram_ctrl: RTL

Converts a 32-bit valid/ready request stream into halfword access sequences on the `ctrl_*` port of `async_sram_phy` (16-bit external async SRAM). It sits directly upstream of the PHY and drives every `ctrl_*` input from a register. It compensates for the PHY's one-cycle registered address/command path and its combinational DQ path, inserting bus turnaround where needed. Read data is captured from `ctrl_dq_in` and returned as one 32-bit response.

---
 rtl/async_sram_ctrl.sv | 135 +++++++++++++
 1 files changed

// File: rtl/async_sram_ctrl.sv
// 32-bit valid/ready request stream to halfword command sequences for async_sram_phy.
// Compensates for the PHY's registered command path and its combinational DQ path.
module async_sram_ctrl #(
  parameter int W_ADDR = 18,
  parameter int W_DATA = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [W_ADDR-2:0]     req_addr,
  input  logic [2*W_DATA-1:0]   req_wdata,
  input  logic [3:0]            req_wstrb,
  output logic                  resp_valid,
  output logic [2*W_DATA-1:0]   resp_rdata,
  output logic [W_ADDR-1:0]     ctrl_addr,
  output logic [W_DATA-1:0]     ctrl_dq_out,
  output logic [W_DATA-1:0]     ctrl_dq_oe,
  input  logic [W_DATA-1:0]     ctrl_dq_in,
  output logic                  ctrl_ce_n,
  output logic                  ctrl_we_n,
  output logic                  ctrl_oe_n,
  output logic [1:0]            ctrl_byte_n,
  output logic [2:0]            dbg_state
);
  // Handshake: a request transfers on any posedge where req_valid && req_ready;
  // req_ready is registered and depends only on the issue state. resp_valid has no backpressure.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD_LO = 3'd1,
    S_RD_HI = 3'd2,
    S_WR_LO = 3'd3,
    S_WR_HI = 3'd4,
    S_TURN  = 3'd5
  } state_t;

  state_t              state, state_nx;
  logic                accept;
  logic [W_ADDR-2:0]   word_q, src_word;
  logic [2*W_DATA-1:0] wdata_q;
  logic [3:0]          wstrb_q, src_wstrb;
  logic                rd_p1_valid, rd_p1_half;
  logic [W_DATA-1:0]   rd_lo_q;

  assign accept    = req_valid && req_ready;
  assign dbg_state = state;
  // A low-half issue takes fresh request fields on accept, latched ones after TURN.
  assign src_word  = accept ? req_addr : word_q;
  assign src_wstrb = accept ? req_wstrb : wstrb_q;

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_RD_HI, S_WR_HI: begin
        if (!accept)        state_nx = S_IDLE;
        else if (!req_write) state_nx = S_RD_LO;
        else if (state == S_RD_HI) state_nx = S_TURN;
        else                state_nx = S_WR_LO;
      end
      S_RD_LO: state_nx = S_RD_HI;
      S_WR_LO: state_nx = S_WR_HI;
      S_TURN:  state_nx = S_WR_LO;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      req_ready   <= 1'b0;
      ctrl_addr   <= '0;
      ctrl_dq_out <= '0;
      ctrl_dq_oe  <= '0;
      ctrl_ce_n   <= 1'b0;
      ctrl_we_n   <= 1'b1;
      ctrl_oe_n   <= 1'b1;
      ctrl_byte_n <= 2'b11;
      word_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rd_p1_valid <= 1'b0;
      rd_p1_half  <= 1'b0;
      rd_lo_q     <= '0;
      resp_valid  <= 1'b0;
      resp_rdata  <= '0;
    end else begin
      state     <= state_nx;
      req_ready <= (state_nx == S_IDLE) || (state_nx == S_RD_HI) || (state_nx == S_WR_HI);
      if (accept) begin
        word_q  <= req_addr;
        wdata_q <= req_wdata;
        wstrb_q <= req_wstrb;
      end

      ctrl_we_n   <= 1'b1;
      ctrl_oe_n   <= 1'b1;
      ctrl_byte_n <= 2'b11;
      case (state_nx)
        S_RD_LO: begin
          ctrl_addr   <= {src_word, 1'b0};
          ctrl_oe_n   <= 1'b0;
          ctrl_byte_n <= 2'b00;
        end
        S_RD_HI: begin
          ctrl_addr   <= {word_q, 1'b1};
          ctrl_oe_n   <= 1'b0;
          ctrl_byte_n <= 2'b00;
        end
        S_WR_LO: begin
          ctrl_addr   <= {src_word, 1'b0};
          ctrl_we_n   <= 1'b0;
          ctrl_byte_n <= ~src_wstrb[1:0];
        end
        S_WR_HI: begin
          ctrl_addr   <= {word_q, 1'b1};
          ctrl_we_n   <= 1'b0;
          ctrl_byte_n <= ~wstrb_q[3:2];
        end
        default: ;
      endcase

      // The PHY delays commands a cycle, so write data goes out the cycle after its issue.
      ctrl_dq_oe <= (state == S_WR_LO || state == S_WR_HI) ? {W_DATA{1'b1}} : {W_DATA{1'b0}};
      if (state == S_WR_LO)      ctrl_dq_out <= wdata_q[W_DATA-1:0];
      else if (state == S_WR_HI) ctrl_dq_out <= wdata_q[2*W_DATA-1:W_DATA];

      rd_p1_valid <= (state == S_RD_LO) || (state == S_RD_HI);
      rd_p1_half  <= (state == S_RD_HI);
      resp_valid  <= rd_p1_valid && rd_p1_half;
      if (rd_p1_valid && !rd_p1_half) rd_lo_q <= ctrl_dq_in;
      if (rd_p1_valid && rd_p1_half)  resp_rdata <= {ctrl_dq_in, rd_lo_q};
    end
  end
endmodule
